// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO controllers: pointer geometry,
// requester select encoding and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int FIFO_PTR_W = 4;
    localparam int FIFO_DEPTH = 2 ** (FIFO_PTR_W - 1);
    // Helpers work on a wide vector; callers zero-extend and truncate with casts.
    localparam int FN_W = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_sel_e;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ff_sync2.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer crossing clock domains.
module ff_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Two-stage capture of the foreign-domain value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side async FIFO controller: round-robin merge of two requesters onto the
// memory write port, write pointers, and pessimistic full / count / almost-full.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDRESS   = FIFO_PTR_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_THRESH = 6
) (
    input  logic               W_CLK,
    input  logic               W_RST,
    input  logic               REQ0_VALID,
    input  logic [WIDTH-1:0]   REQ0_DATA,
    output logic               GNT0,
    input  logic               REQ1_VALID,
    input  logic [WIDTH-1:0]   REQ1_DATA,
    output logic               GNT1,
    input  logic [ADDRESS-1:0] R_PTR,
    output logic               W_INC,
    output logic [WIDTH-1:0]   W_DATA,
    output logic [ADDRESS-2:0] W_ADDR,
    output logic [ADDRESS-1:0] W_PTR,
    output logic               W_FULL,
    output logic               ALMOST_FULL,
    output logic [ADDRESS-1:0] W_COUNT
);

    localparam int AW = $clog2(DEPTH);

    logic [ADDRESS-1:0] wbin_q, wbin_d;
    logic [ADDRESS-1:0] wptr_q, wptr_d;
    logic [ADDRESS-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    req_sel_e           last_q, last_d;
    req_sel_e           sel_s;
    logic               winc_s;
    logic [ADDRESS-1:0] rq2_s;
    logic [ADDRESS-1:0] rbin_s;

    ff_sync2 #(.WIDTH(ADDRESS)) u_rptr_sync (
        .clk_i   (W_CLK),
        .rst_n_i (W_RST),
        .d_i     (R_PTR),
        .q_o     (rq2_s)
    );

    // Round-robin select; grants are also held off while reset is asserted.
    always_comb begin
        sel_s = REQ0;
        if (REQ0_VALID && REQ1_VALID) begin
            if (last_q == REQ0) begin
                sel_s = REQ1;
            end else begin
                sel_s = REQ0;
            end
        end else if (REQ1_VALID) begin
            sel_s = REQ1;
        end else begin
            sel_s = REQ0;
        end
        winc_s = (REQ0_VALID | REQ1_VALID) & ~full_q & W_RST;
    end

    // Next pointer, and flags computed from the next pointer so full lands with the last write.
    always_comb begin
        wbin_d = wbin_q;
        last_d = last_q;
        if (winc_s) begin
            wbin_d = wbin_q + ADDRESS'(1);
            last_d = sel_s;
        end else begin
            wbin_d = wbin_q;
            last_d = last_q;
        end
        rbin_s  = ADDRESS'(gray2bin(FN_W'(rq2_s)));
        wptr_d  = ADDRESS'(bin2gray(FN_W'(wbin_d)));
        full_d  = (wptr_d == {~rq2_s[ADDRESS-1:ADDRESS-2], rq2_s[ADDRESS-3:0]});
        count_d = wbin_d - rbin_s;
        af_d    = (count_d >= ADDRESS'(AF_THRESH));
    end

    // Write-domain state registers.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin_q  <= {ADDRESS{1'b0}};
            wptr_q  <= {ADDRESS{1'b0}};
            count_q <= {ADDRESS{1'b0}};
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            last_q  <= REQ1;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            af_q    <= af_d;
            last_q  <= last_d;
        end
    end

    assign W_INC       = winc_s;
    assign GNT0        = winc_s & (sel_s == REQ0);
    assign GNT1        = winc_s & (sel_s == REQ1);
    assign W_DATA      = (sel_s == REQ1) ? REQ1_DATA : REQ0_DATA;
    assign W_ADDR      = wbin_q[AW-1:0];
    assign W_PTR       = wptr_q;
    assign W_FULL      = full_q;
    assign ALMOST_FULL = af_q;
    assign W_COUNT     = count_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl with default parameters.
module tb_fifo_wr_ctrl;

    logic       W_CLK;
    logic       W_RST;
    logic       REQ0_VALID;
    logic [7:0] REQ0_DATA;
    logic       GNT0;
    logic       REQ1_VALID;
    logic [7:0] REQ1_DATA;
    logic       GNT1;
    logic [3:0] R_PTR;
    logic       W_INC;
    logic [7:0] W_DATA;
    logic [2:0] W_ADDR;
    logic [3:0] W_PTR;
    logic       W_FULL;
    logic       ALMOST_FULL;
    logic [3:0] W_COUNT;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] GRAY_T [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    fifo_wr_ctrl #(
        .WIDTH(8), .ADDRESS(4), .DEPTH(8), .AF_THRESH(6)
    ) dut (
        .W_CLK       (W_CLK),
        .W_RST       (W_RST),
        .REQ0_VALID  (REQ0_VALID),
        .REQ0_DATA   (REQ0_DATA),
        .GNT0        (GNT0),
        .REQ1_VALID  (REQ1_VALID),
        .REQ1_DATA   (REQ1_DATA),
        .GNT1        (GNT1),
        .R_PTR       (R_PTR),
        .W_INC       (W_INC),
        .W_DATA      (W_DATA),
        .W_ADDR      (W_ADDR),
        .W_PTR       (W_PTR),
        .W_FULL      (W_FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .W_COUNT     (W_COUNT)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge W_CLK);
        #1;
    endtask

    initial begin
        W_RST = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_DATA = 8'h00; REQ1_DATA = 8'h00; R_PTR = 4'h0;
        #2;
        chk("rst_wptr",  32'(W_PTR),       32'd0);
        chk("rst_waddr", 32'(W_ADDR),      32'd0);
        chk("rst_full",  32'(W_FULL),      32'd0);
        chk("rst_af",    32'(ALMOST_FULL), 32'd0);
        chk("rst_count", 32'(W_COUNT),     32'd0);
        chk("rst_winc",  32'(W_INC),       32'd0);
        tick();
        W_RST = 1'b1;

        // Fill with R_PTR = 0
        for (int i = 0; i < 8; i++) begin
            REQ0_VALID = 1'b1;
            REQ0_DATA  = 8'hA0 + 8'(i);
            #1;
            chk("fill_gnt0",  32'(GNT0),   32'd1);
            chk("fill_gnt1",  32'(GNT1),   32'd0);
            chk("fill_waddr", 32'(W_ADDR), 32'(i));
            chk("fill_wdata", 32'(W_DATA), 32'(8'hA0 + 8'(i)));
            tick();
            chk("fill_wptr",  32'(W_PTR),       32'(GRAY_T[i+1]));
            chk("fill_count", 32'(W_COUNT),     32'(i + 1));
            chk("fill_af",    32'(ALMOST_FULL), (i >= 5) ? 32'd1 : 32'd0);
            chk("fill_full",  32'(W_FULL),      (i == 7) ? 32'd1 : 32'd0);
        end
        REQ0_DATA = 8'hA8;
        #1;
        chk("held_gnt0", 32'(GNT0),  32'd0);
        chk("held_winc", 32'(W_INC), 32'd0);
        tick();
        chk("held_wptr",  32'(W_PTR),   32'hC);
        chk("held_count", 32'(W_COUNT), 32'd8);
        chk("held_full",  32'(W_FULL),  32'd1);

        // Drain release: reader reaches binary 2
        R_PTR = 4'b0011;
        tick();
        chk("drain_full_e1", 32'(W_FULL), 32'd1);
        chk("drain_gnt0_e1", 32'(GNT0),   32'd0);
        tick();
        chk("drain_full_e2", 32'(W_FULL), 32'd1);
        tick();
        chk("drain_full_e3",  32'(W_FULL),      32'd0);
        chk("drain_count_e3", 32'(W_COUNT),     32'd6);
        chk("drain_af_e3",    32'(ALMOST_FULL), 32'd1);
        chk("drain_gnt0",     32'(GNT0),        32'd1);
        chk("drain_waddr0",   32'(W_ADDR),      32'd0);
        chk("drain_wdata0",   32'(W_DATA),      32'hA8);
        tick();
        chk("drain_count7", 32'(W_COUNT), 32'd7);
        chk("drain_full7",  32'(W_FULL),  32'd0);
        chk("drain_wptr9",  32'(W_PTR),   32'hD);
        REQ0_DATA = 8'hA9;
        #1;
        chk("drain_gnt0_2", 32'(GNT0),   32'd1);
        chk("drain_waddr1", 32'(W_ADDR), 32'd1);
        tick();
        chk("drain_refull",  32'(W_FULL),  32'd1);
        chk("drain_count8",  32'(W_COUNT), 32'd8);
        chk("drain_wptr10",  32'(W_PTR),   32'hF);
        REQ0_VALID = 1'b0;

        // Simultaneous write and read at count 7
        R_PTR = 4'b0010;
        tick(); tick(); tick();
        chk("sim_pre_full",  32'(W_FULL),  32'd0);
        chk("sim_pre_count", 32'(W_COUNT), 32'd7);
        REQ0_VALID = 1'b1;
        REQ0_DATA  = 8'hAA;
        R_PTR      = 4'b0110;
        #1;
        chk("sim_gnt0",  32'(GNT0),   32'd1);
        chk("sim_waddr", 32'(W_ADDR), 32'd2);
        tick();
        REQ0_VALID = 1'b0;
        chk("sim_full_e1",  32'(W_FULL),  32'd1);
        chk("sim_count_e1", 32'(W_COUNT), 32'd8);
        chk("sim_wptr_e1",  32'(W_PTR),   32'hE);
        tick();
        chk("sim_full_e2",  32'(W_FULL),  32'd1);
        tick();
        chk("sim_full_e3",  32'(W_FULL),  32'd0);
        chk("sim_count_e3", 32'(W_COUNT), 32'd7);

        // Reset mid-stream at count 5
        W_RST = 1'b0; R_PTR = 4'h0;
        #1;
        W_RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            REQ0_VALID = 1'b1;
            REQ0_DATA  = 8'hB0 + 8'(i);
            tick();
        end
        chk("mid_count5", 32'(W_COUNT), 32'd5);
        chk("mid_wptr5",  32'(W_PTR),   32'h7);
        REQ0_VALID = 1'b1; REQ0_DATA = 8'h11;
        REQ1_VALID = 1'b1; REQ1_DATA = 8'h22;
        W_RST = 1'b0;
        #1;
        chk("mid_wptr",  32'(W_PTR),       32'd0);
        chk("mid_waddr", 32'(W_ADDR),      32'd0);
        chk("mid_count", 32'(W_COUNT),     32'd0);
        chk("mid_full",  32'(W_FULL),      32'd0);
        chk("mid_af",    32'(ALMOST_FULL), 32'd0);
        chk("mid_winc",  32'(W_INC),       32'd0);
        chk("mid_gnt0",  32'(GNT0),        32'd0);
        chk("mid_gnt1",  32'(GNT1),        32'd0);
        tick();
        W_RST = 1'b1;
        #1;
        chk("rr0_gnt0",  32'(GNT0),   32'd1);
        chk("rr0_gnt1",  32'(GNT1),   32'd0);
        chk("rr0_waddr", 32'(W_ADDR), 32'd0);
        chk("rr0_wdata", 32'(W_DATA), 32'h11);

        // Round-robin with both requesters continuously valid
        tick();
        REQ0_DATA = 8'h13;
        #1;
        chk("rr1_gnt0",  32'(GNT0),   32'd0);
        chk("rr1_gnt1",  32'(GNT1),   32'd1);
        chk("rr1_wdata", 32'(W_DATA), 32'h22);
        chk("rr1_waddr", 32'(W_ADDR), 32'd1);
        tick();
        REQ1_DATA = 8'h24;
        #1;
        chk("rr2_gnt0",  32'(GNT0),   32'd1);
        chk("rr2_wdata", 32'(W_DATA), 32'h13);
        chk("rr2_waddr", 32'(W_ADDR), 32'd2);
        tick();
        REQ0_DATA = 8'h15;
        #1;
        chk("rr3_gnt1",  32'(GNT1),   32'd1);
        chk("rr3_wdata", 32'(W_DATA), 32'h24);
        chk("rr3_waddr", 32'(W_ADDR), 32'd3);
        tick();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        chk("rr_count4", 32'(W_COUNT), 32'd4);

        // Wrap: 20 writes with the reader trailing two words behind
        W_RST = 1'b0; R_PTR = 4'h0;
        #1;
        W_RST = 1'b1;
        for (int k = 0; k < 20; k++) begin
            R_PTR      = (k >= 2) ? GRAY_T[(k - 2) % 16] : 4'h0;
            REQ0_VALID = 1'b1;
            REQ0_DATA  = 8'(k);
            #1;
            chk("wrap_gnt0",  32'(GNT0),   32'd1);
            chk("wrap_waddr", 32'(W_ADDR), 32'(k % 8));
            tick();
            chk("wrap_wptr",  32'(W_PTR),       32'(GRAY_T[(k + 1) % 16]));
            chk("wrap_full",  32'(W_FULL),      32'd0);
            chk("wrap_count", 32'(W_COUNT),     (k < 4) ? 32'(k + 1) : 32'd5);
            chk("wrap_af",    32'(ALMOST_FULL), 32'd0);
        end
        REQ0_VALID = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the async FIFO memory, running in the write-clock domain. Arbitrates two write requesters round-robin onto the single memory write port. Owns the binary and Gray write pointers and a 2-FF synchronizer for the read-domain Gray pointer. Produces the registered full flag, the occupancy count and the almost-full flag.

Parameters:
WIDTH, 8, data word width
ADDRESS, 4, pointer width; one wrap bit plus ADDRESS-1 memory address bits
DEPTH, 8, memory depth; must equal 2**(ADDRESS-1)
AF_THRESH, 6, ALMOST_FULL asserts when W_COUNT >= AF_THRESH (1..DEPTH)

Ports:
W_CLK  in  1  write-domain clock
W_RST  in  1  asynchronous, active-low reset
REQ0_VALID  in  1  requester 0 has a word
REQ0_DATA  in  WIDTH  requester 0 word
GNT0  out  1  requester 0 word accepted this cycle (combinational)
REQ1_VALID  in  1  requester 1 has a word
REQ1_DATA  in  WIDTH  requester 1 word
GNT1  out  1  requester 1 word accepted this cycle (combinational)
R_PTR  in  ADDRESS  Gray read pointer from the read domain (asynchronous)
W_INC  out  1  memory write strobe
W_DATA  out  WIDTH  memory write data
W_ADDR  out  ADDRESS-1  memory write address; low bits of the binary write pointer
W_PTR  out  ADDRESS  registered Gray write pointer, sent to the read domain
W_FULL  out  1  registered full flag
ALMOST_FULL  out  1  registered, W_COUNT >= AF_THRESH
W_COUNT  out  ADDRESS  registered occupancy, 0..DEPTH

Behaviour:
- Reset (W_RST low, async): wbin, W_PTR, both synchronizer stages, W_COUNT = 0; W_FULL, ALMOST_FULL = 0; last_gnt = 1 so REQ0 wins the first tie.
- Synchronizer: rq1 <= R_PTR; rq2 <= rq1. Only rq2 is used. Read-pointer updates are seen 2 cycles late, so full and count are pessimistic and never optimistic.
- Arbitration (combinational):
  - sel = REQ1 if only REQ1_VALID; REQ0 if only REQ0_VALID.
  - If both are valid, sel = the requester that is not last_gnt.
  - W_INC = (REQ0_VALID | REQ1_VALID) & !W_FULL.
  - GNTx = W_INC & (sel == x). At most one grant is high.
- W_DATA = data of sel. W_DATA is a don't-care when W_INC = 0; drive the REQ0 mux path.
- Handshake: a requester holds VALID and DATA stable until its GNT. The transfer completes at the W_CLK edge where GNT = 1.
- On a W_INC edge:
  - wbin <= wbin + 1, wrapping mod 2**ADDRESS.
  - last_gnt <= sel.
  - W_PTR <= gray(wbin_next), where gray(b) = b ^ (b>>1).
- W_FULL <= (gray(wbin_next) == {~rq2[A-1:A-2], rq2[A-3:0]}). It is registered from the next pointer, so it asserts at the same edge that commits the DEPTH-th write. No write is ever issued while full.
- W_COUNT <= (wbin_next - bin(rq2)) mod 2**ADDRESS. ALMOST_FULL <= (that value >= AF_THRESH). Both update every cycle, including cycles where only rq2 changes.
- Full deasserts 1 cycle after rq2 shows read progress, which is 3 W_CLK edges after R_PTR changes.
- Wrap: W_ADDR goes 7 -> 0 while the MSB of wbin toggles, and the Gray pointer changes by one bit per increment.
- Reset mid-operation: all state is cleared immediately. The requester in flight is not granted.

Decomposition:
- Shared package fifo_pkg: bin2gray and gray2bin functions, and the constants DEPTH = 2**(ADDRESS-1) and the pointer width.
- Sub-module ff_sync2 (parameterised width, two-flop synchronizer with async active-low reset). The read-side controller reuses it.

Test Plan:
- Fill, R_PTR = 0: REQ0 streams 8 words -> GNT0 high 8 cycles; W_ADDR 0..7; W_PTR sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100. W_FULL = 1 and W_COUNT = 8 after the 8th edge. A 9th word is held with GNT0 = 0. ALMOST_FULL rises after the 6th write.
- Round-robin: both VALID continuously with an empty FIFO -> grants REQ0, REQ1, REQ0, REQ1. Data order at W_DATA matches. Neither requester is starved.
- Drain release: full, then R_PTR = 0011 (bin 2) -> W_FULL stays 1 for two edges, drops on the 3rd edge. W_COUNT = 6, and two more writes are accepted.
- Wrap: 20 writes with R_PTR tracking 2 behind (Gray) -> W_ADDR wraps 7 -> 0. W_PTR passes 1000 and returns to 0000. W_FULL is never set.
- Simultaneous write and read: at count 7, write and R_PTR advance in the same cycle -> the write is accepted. W_FULL is 1 for 2 cycles, then W_COUNT settles at 7.
- Reset mid-stream: W_RST low at count 5 -> all outputs 0 at once with no clock. After release, the REQ0 and REQ1 tie goes to REQ0 and W_ADDR = 0.
